// File: rtl/cpu_pkg.sv
// Shared matrix-CPU definitions: opcode values, opcode field positions and
// the instruction sequencer state type.
package cpu_pkg;

    localparam int unsigned OPCODE_W  = 27;

    localparam int unsigned INSTR_HI  = 26;
    localparam int unsigned INSTR_LO  = 22;
    localparam int unsigned DEST_HI   = 21;
    localparam int unsigned DEST_LO   = 15;
    localparam int unsigned SRC1_HI   = 14;
    localparam int unsigned SRC1_LO   = 8;
    localparam int unsigned SRC2_HI   = 7;
    localparam int unsigned SRC2_LO   = 1;
    localparam int unsigned SCALAR_HI = 7;
    localparam int unsigned SCALAR_LO = 0;

    localparam logic [4:0] OP_NOP       = 5'h00;
    localparam logic [4:0] OP_ADD       = 5'h01;
    localparam logic [4:0] OP_SUB       = 5'h02;
    localparam logic [4:0] OP_MUL       = 5'h03;
    localparam logic [4:0] OP_TRANSPOSE = 5'h04;
    localparam logic [4:0] OP_SCALE     = 5'h05;
    localparam logic [4:0] OP_HALT      = 5'h1F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_MEMWAIT,
        ST_DECODE,
        ST_ISSUE,
        ST_EXEC,
        ST_HALT
    } seq_state_t;

endpackage

// File: rtl/opcode_fields.sv
// Combinational split of a 27-bit opcode into its instruction fields.
// The scalar field deliberately overlaps src2.
module opcode_fields
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output logic [4:0]          instr,
    output logic [6:0]          dest,
    output logic [6:0]          src1,
    output logic [6:0]          src2,
    output logic [7:0]          scalar
);

    assign instr  = opcode[INSTR_HI:INSTR_LO];
    assign dest   = opcode[DEST_HI:DEST_LO];
    assign src1   = opcode[SRC1_HI:SRC1_LO];
    assign src2   = opcode[SRC2_HI:SRC2_LO];
    assign scalar = opcode[SCALAR_HI:SCALAR_LO];

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/issue controller: reads opcodes from synchronous instruction
// memory, issues them to the execution engine and waits for completion.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned INSTR_W   = 27,
    parameter int unsigned LAST_ADDR = 15,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic               instr_rd,
    input  logic [INSTR_W-1:0] instr_word,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [4:0]         dec_instr,
    output logic [6:0]         dec_dest,
    output logic [6:0]         dec_src1,
    output logic [6:0]         dec_src2,
    output logic [7:0]         dec_scalar,
    input  logic               exe_done,
    output logic               busy,
    output logic               halted,
    output logic               error
);

    localparam int unsigned       CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);
    localparam logic [CNT_W-1:0]  TMO_CNT = CNT_W'(TIMEOUT);

    seq_state_t        state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              err_q, err_nxt;
    logic              capture;
    logic              advance;

    logic [4:0] f_instr;
    logic [6:0] f_dest, f_src1, f_src2;
    logic [7:0] f_scalar;

    opcode_fields u_fields (
        .opcode (instr_word),
        .instr  (f_instr),
        .dest   (f_dest),
        .src1   (f_src1),
        .src2   (f_src2),
        .scalar (f_scalar)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            dec_instr  <= '0;
            dec_dest   <= '0;
            dec_src1   <= '0;
            dec_src2   <= '0;
            dec_scalar <= '0;
        end else begin
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
            if (capture) begin
                dec_instr  <= f_instr;
                dec_dest   <= f_dest;
                dec_src1   <= f_src1;
                dec_src2   <= f_src2;
                dec_scalar <= f_scalar;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        err_nxt   = err_q;
        capture   = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_nxt    = '0;
                    err_nxt   = 1'b0;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH:   state_nxt = ST_MEMWAIT;
            ST_MEMWAIT: begin
                capture   = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_instr == OP_HALT) begin
                    state_nxt = ST_HALT;
                end else if (dec_instr == OP_NOP) begin
                    advance = 1'b1;
                end else begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_ready) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // completion takes priority over a timeout in the same cycle
                if (exe_done) begin
                    advance = 1'b1;
                end else if (cnt == TMO_CNT) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_HALT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (advance) begin
            if (pc == LAST_PC) begin
                state_nxt = ST_HALT;
            end else begin
                pc_nxt    = pc + 1'b1;
                state_nxt = ST_FETCH;
            end
        end
    end

    assign instr_addr  = pc;
    assign instr_rd    = (state == ST_FETCH);
    assign issue_valid = (state == ST_ISSUE);
    assign busy        = (state != ST_IDLE) && (state != ST_HALT);
    assign halted      = (state == ST_HALT);
    assign error       = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: memory and engine models drive the DUT,
// a program-level reference predicts fetches, issues, cycle count and error.
module tb_instr_sequencer;

    localparam logic [4:0] T_NOP   = 5'h00;
    localparam logic [4:0] T_ADD   = 5'h01;
    localparam logic [4:0] T_SCALE = 5'h05;
    localparam logic [4:0] T_HALT  = 5'h1F;
    localparam int         EXEC_LIMIT = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  instr_addr;
    logic        instr_rd;
    logic [26:0] instr_word = '0;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  dec_instr;
    logic [6:0]  dec_dest, dec_src1, dec_src2;
    logic [7:0]  dec_scalar;
    logic        exe_done;
    logic        busy, halted, error;

    logic [26:0] mem [16];
    int          rw  [16];
    int          dd  [16];

    int n_checks = 0;
    int n_fail   = 0;

    instr_sequencer #(
        .ADDR_W    (4),
        .INSTR_W   (27),
        .LAST_ADDR (15),
        .TIMEOUT   (255)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instr_addr  (instr_addr),
        .instr_rd    (instr_rd),
        .instr_word  (instr_word),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .dec_instr   (dec_instr),
        .dec_dest    (dec_dest),
        .dec_src1    (dec_src1),
        .dec_src2    (dec_src2),
        .dec_scalar  (dec_scalar),
        .exe_done    (exe_done),
        .busy        (busy),
        .halted      (halted),
        .error       (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (instr_rd) instr_word <= mem[instr_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs();
        check("rst_addr",   instr_addr,  0);
        check("rst_rd",     instr_rd,    0);
        check("rst_valid",  issue_valid, 0);
        check("rst_instr",  dec_instr,   0);
        check("rst_dest",   dec_dest,    0);
        check("rst_src1",   dec_src1,    0);
        check("rst_src2",   dec_src2,    0);
        check("rst_scalar", dec_scalar,  0);
        check("rst_busy",   busy,        0);
        check("rst_halted", halted,      0);
        check("rst_error",  error,       0);
    endtask

    function automatic logic [26:0] mk(input logic [4:0] op, input logic [6:0] d,
                                       input logic [6:0] s1, input logic [6:0] s2);
        return {op, d, s1, s2, 1'b0};
    endfunction

    task automatic clear_prog();
        for (int a = 0; a < 16; a++) begin
            mem[a] = {T_HALT, 22'd0};
            rw[a]  = 0;
            dd[a]  = 1;
        end
    endtask

    // abort_at > 0: pull reset low in that EXEC cycle of the first issue
    task automatic run_prog(input int abort_at);
        int unsigned exp_fetch[$];
        int unsigned exp_issue[$];
        int          exp_total;
        logic        exp_err;
        int          busy_cnt, fi, ii, vw, ek, cur;
        logic        in_exec, stop;
        logic [26:0] w;

        exp_total = 0;
        exp_err   = 1'b0;
        for (int a = 0; a < 16; a++) begin
            exp_fetch.push_back(a);
            exp_total += 3;
            w = mem[a];
            if (w[26:22] == T_HALT) break;
            if (w[26:22] != T_NOP) begin
                exp_issue.push_back(a);
                exp_total += rw[a] + 1;
                if (dd[a] == 0) begin
                    exp_total += EXEC_LIMIT;
                    exp_err = 1'b1;
                    break;
                end
                exp_total += dd[a];
            end
        end

        @(negedge clk);
        start = 1'b1; issue_ready = 1'b0; exe_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("err_clear_on_start", error, 0);

        busy_cnt = 0; fi = 0; ii = 0; vw = 0; ek = 0; cur = 0;
        in_exec = 1'b0; stop = 1'b0;
        for (int cyc = 0; cyc < exp_total + 20 && !halted && !stop; cyc++) begin
            if (busy) busy_cnt++;
            if (instr_rd) begin
                if (fi < exp_fetch.size()) check("fetch_addr", instr_addr, exp_fetch[fi]);
                else check("fetch_count", fi + 1, exp_fetch.size());
                fi++;
            end
            if (in_exec) begin
                ek++;
                check("exec_valid_low", issue_valid, 0);
                if (abort_at > 0 && ek == abort_at) begin
                    reset = 1'b0; exe_done = 1'b0; issue_ready = 1'b0;
                    #1;
                    check_idle_outputs();
                    @(negedge clk);
                    reset = 1'b1;
                    stop = 1'b1;
                end else begin
                    exe_done    = (dd[cur] != 0) && (ek == dd[cur]);
                    issue_ready = 1'($urandom % 2);
                    if (exe_done) in_exec = 1'b0;
                end
            end else begin
                exe_done = ($urandom % 4 == 0);
                if (issue_valid) begin
                    if (ii < exp_issue.size()) begin
                        cur = exp_issue[ii];
                        w   = mem[cur];
                        check("issue_addr",   instr_addr, cur);
                        check("issue_instr",  dec_instr,  w[26:22]);
                        check("issue_dest",   dec_dest,   w[21:15]);
                        check("issue_src1",   dec_src1,   w[14:8]);
                        check("issue_src2",   dec_src2,   w[7:1]);
                        check("issue_scalar", dec_scalar, w[7:0]);
                        vw++;
                        issue_ready = (vw > rw[cur]);
                        if (issue_ready) begin
                            in_exec = 1'b1; ek = 0; vw = 0; ii++;
                        end
                    end else begin
                        check("issue_count", ii + 1, exp_issue.size());
                        stop = 1'b1;
                    end
                end else begin
                    issue_ready = 1'($urandom % 2);
                end
            end
            if (!stop) @(negedge clk);
        end

        exe_done = 1'b0; issue_ready = 1'b0;
        if (abort_at == 0) begin
            check("end_halted",  halted,   1);
            check("end_busy",    busy,     0);
            check("end_error",   error,    exp_err);
            check("busy_cycles", busy_cnt, exp_total);
            check("fetches",     fi,       exp_fetch.size());
            check("issues",      ii,       exp_issue.size());
        end
    endtask

    initial begin
        logic [4:0] op;
        int         r;

        reset = 1'b0; start = 1'b0; issue_ready = 1'b0; exe_done = 1'b0;
        clear_prog();
        repeat (2) @(negedge clk);
        check_idle_outputs();
        reset = 1'b1;

        // add then HALT, engine ready at once, done after 5 cycles
        clear_prog();
        mem[0] = mk(T_ADD, 7'd2, 7'd0, 7'd1);
        dd[0]  = 5;
        run_prog(0);

        // ready held low for 10 issue cycles
        rw[0] = 10; dd[0] = 3;
        run_prog(0);

        // 15 NOPs then a scale at the last address: no wrap
        clear_prog();
        for (int a = 0; a < 15; a++) mem[a] = {T_NOP, 22'd0};
        mem[15] = {T_SCALE, 7'd9, 7'd3, 8'h05};
        rw[15] = 1; dd[15] = 2;
        run_prog(0);
        check("scalar_hold", dec_scalar, 8'h05);
        check("halt_addr",   instr_addr, 15);

        // timeout, then restart from HALT clears the error
        clear_prog();
        mem[0] = mk(T_ADD, 7'd4, 7'd5, 7'd6);
        dd[0]  = 0;
        run_prog(0);
        dd[0]  = 2;
        run_prog(0);

        // reset in the middle of EXEC, then a clean run from IDLE
        dd[0] = 0;
        run_prog(20);
        check_idle_outputs();
        dd[0] = 4;
        run_prog(0);

        for (int t = 0; t < 10; t++) begin
            for (int a = 0; a < 16; a++) begin
                r  = int'($urandom % 16);
                op = (r < 5) ? T_NOP : (r == 5) ? T_HALT : 5'(1 + r % 5);
                mem[a] = {op, 22'($urandom)};
                rw[a]  = int'($urandom % 4);
                dd[a]  = ($urandom % 25 == 0) ? 0 : int'(1 + $urandom % 6);
            end
            run_prog(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
